// File: rtl/friscv_gpio_filter.sv
// ----------------------------------------------------------------------------
// friscv_gpio_filter
//
// Input conditioning for the GPIO block: every raw pad input is brought into
// the aclk domain through a synchronizer chain, then debounced by a per-bit
// saturating counter. The debounced levels feed the GPIO register block.
// Filtered transitions produce registered one-cycle rise/fall pulses, which in
// turn set sticky, maskable, write-1-to-clear interrupt pending flags.
//
// Parameters
//   XLEN         number of GPIO pins
//   SYNC_STAGES  synchronizer depth (2..4)
//   DEBOUNCE_W   width of the debounce counters and of cfg_debounce
//
// Ports
//   aclk          clock, all logic on the rising edge
//   aresetn       asynchronous active-low reset
//   srst          synchronous active-high reset, highest priority
//   cfg_en        1 = debounce active, 0 = filter bypassed (sync level passes)
//   cfg_debounce  debounce threshold in cycles
//   pin_in        raw asynchronous pad inputs
//   gpio_in       filtered pin levels
//   rise_pulse    one-cycle pulse per bit on a filtered 0->1 transition
//   fall_pulse    one-cycle pulse per bit on a filtered 1->0 transition
//   irq_mask      per-bit edge interrupt enable
//   irq_ack       per-bit write-1-to-clear of irq_pending
//   irq_pending   sticky per-bit edge-event flags
//   irq           OR of irq_pending
// ----------------------------------------------------------------------------
module friscv_gpio_filter #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  cfg_en,
    input  logic [DEBOUNCE_W-1:0] cfg_debounce,
    input  logic [XLEN-1:0]       pin_in,
    output logic [XLEN-1:0]       gpio_in,
    output logic [XLEN-1:0]       rise_pulse,
    output logic [XLEN-1:0]       fall_pulse,
    input  logic [XLEN-1:0]       irq_mask,
    input  logic [XLEN-1:0]       irq_ack,
    output logic [XLEN-1:0]       irq_pending,
    output logic                  irq
);

    logic [XLEN-1:0]       sync_q [SYNC_STAGES];
    logic [XLEN-1:0]       sync_d [SYNC_STAGES];
    logic [DEBOUNCE_W-1:0] cnt_q  [XLEN];
    logic [DEBOUNCE_W-1:0] cnt_d  [XLEN];
    logic [XLEN-1:0]       filt_q, filt_d;
    logic [XLEN-1:0]       rise_q, rise_d;
    logic [XLEN-1:0]       fall_q, fall_d;
    logic [XLEN-1:0]       pend_q, pend_d;
    logic [XLEN-1:0]       sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        // Synchronizer chain: stage 0 samples the pad, last stage is used.
        sync_d[0] = pin_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        // Debounce: a differing level must persist until the counter reaches
        // the threshold. The compare is >= so lowering cfg_debounce below an
        // in-flight count commits on the next edge, and the counter stops at
        // the threshold so it can never wrap.
        filt_d = filt_q;
        for (int i = 0; i < XLEN; i++) begin
            cnt_d[i] = '0;
            if (!cfg_en) begin
                filt_d[i] = sync_lvl[i];
            end else if (sync_lvl[i] != filt_q[i]) begin
                if (cnt_q[i] >= cfg_debounce) begin
                    filt_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
                end
            end
        end

        // Pulses are registered alongside filt, so they are high exactly in the
        // first cycle gpio_in shows the new level.
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;

        // Set wins over a simultaneous acknowledge so no edge event is lost.
        pend_d = (pend_q & ~irq_ack) | ((rise_q | fall_q) & irq_mask);

        if (srst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_d[k] = '0;
            end
            for (int i = 0; i < XLEN; i++) begin
                cnt_d[i] = '0;
            end
            filt_d = '0;
            rise_d = '0;
            fall_d = '0;
            pend_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < XLEN; i++) begin
                cnt_q[i] <= '0;
            end
            filt_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < XLEN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign gpio_in     = filt_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign irq_pending = pend_q;
    assign irq         = |pend_q;

endmodule

// File: tb/tb_friscv_gpio_filter.sv
// ----------------------------------------------------------------------------
// tb_friscv_gpio_filter
//
// Directed bench for friscv_gpio_filter. Stimulus schedules the expected
// output state for specific cycle numbers into a queue; an independent monitor
// samples the outputs on each falling edge, pops every expectation due for that
// cycle and compares it. Any rise/fall pulse in a cycle with no expectation is
// reported as unexpected.
// ----------------------------------------------------------------------------
module tb_friscv_gpio_filter;

    localparam int XLEN = 32;
    localparam int DW   = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            srst;
    logic            cfg_en;
    logic [DW-1:0]   cfg_debounce;
    logic [XLEN-1:0] pin_in;
    logic [XLEN-1:0] gpio_in;
    logic [XLEN-1:0] rise_pulse;
    logic [XLEN-1:0] fall_pulse;
    logic [XLEN-1:0] irq_mask;
    logic [XLEN-1:0] irq_ack;
    logic [XLEN-1:0] irq_pending;
    logic            irq;

    friscv_gpio_filter #(
        .XLEN        (XLEN),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (DW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .srst         (srst),
        .cfg_en       (cfg_en),
        .cfg_debounce (cfg_debounce),
        .pin_in       (pin_in),
        .gpio_in      (gpio_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .irq_mask     (irq_mask),
        .irq_ack      (irq_ack),
        .irq_pending  (irq_pending),
        .irq          (irq)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          cyc;
        logic [31:0] gpio;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] pend;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [31:0] g, input logic [31:0] r,
                             input logic [31:0] f, input logic [31:0] p, input string nm);
        exp_t e;
        e.cyc  = c;
        e.gpio = g;
        e.rise = r;
        e.fall = f;
        e.pend = p;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Monitor
    initial begin
        forever begin
            bit   matched;
            exp_t e;
            @(negedge aclk);
            matched = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cyc);
                end else begin
                    matched = 1'b1;
                    chk({e.name, ".gpio_in"},     gpio_in,     e.gpio);
                    chk({e.name, ".rise_pulse"},  rise_pulse,  e.rise);
                    chk({e.name, ".fall_pulse"},  fall_pulse,  e.fall);
                    chk({e.name, ".irq_pending"}, irq_pending, e.pend);
                    chk({e.name, ".irq"},         {31'b0, irq}, {31'b0, |e.pend});
                end
            end
            if (!matched && ((rise_pulse | fall_pulse) != '0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse @cyc %0d: rise %h fall %h, expected none",
                         cyc, rise_pulse, fall_pulse);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int c0;
        int c1;
        int c2;
        aresetn      = 1'b0;
        srst         = 1'b0;
        cfg_en       = 1'b1;
        cfg_debounce = 8'd3;
        pin_in       = '0;
        irq_mask     = '0;
        irq_ack      = '0;
        expect_at(1, 32'h0, 32'h0, 32'h0, 32'h0, "reset");
        #16;
        aresetn = 1'b1;

        // Stable rise on bit 0, debounce 3: visible after 6 cycles.
        c0 = cyc;
        pin_in[0] = 1'b1;
        expect_at(c0 + 5, 32'h1 & 32'h0, 32'h0, 32'h0, 32'h0, "deb3_before");
        expect_at(c0 + 6, 32'h1, 32'h1, 32'h0, 32'h0, "deb3_rise");
        expect_at(c0 + 7, 32'h1, 32'h0, 32'h0, 32'h0, "deb3_after");
        step(10);

        // Three-cycle glitch on bit 5 is rejected.
        c0 = cyc;
        pin_in[5] = 1'b1;
        expect_at(c0 + 5, 32'h1, 32'h0, 32'h0, 32'h0, "glitch_mid");
        expect_at(c0 + 9, 32'h1, 32'h0, 32'h0, 32'h0, "glitch_end");
        step(3);
        pin_in[5] = 1'b0;
        step(8);

        // Debounce 0: one cycle of filter latency.
        c0 = cyc;
        cfg_debounce = 8'd0;
        pin_in[1] = 1'b1;
        expect_at(c0 + 2, 32'h1, 32'h0, 32'h0, 32'h0, "deb0_before");
        expect_at(c0 + 3, 32'h3, 32'h2, 32'h0, 32'h0, "deb0_rise");
        step(6);

        // Lower the threshold below an in-flight count: commits next edge.
        c0 = cyc;
        cfg_debounce = 8'd7;
        pin_in[1] = 1'b0;
        expect_at(c0 + 5, 32'h3, 32'h0, 32'h0, 32'h0, "lower_before");
        expect_at(c0 + 6, 32'h1, 32'h0, 32'h2, 32'h0, "lower_fall");
        step(5);
        cfg_debounce = 8'd1;
        step(5);
        cfg_debounce = 8'd3;

        // Bypass pulsed mid-count: filt takes the synced level, stays sane.
        c0 = cyc;
        pin_in[3] = 1'b1;
        expect_at(c0 + 4, 32'h1, 32'h0, 32'h0, 32'h0, "bypass_mid_before");
        expect_at(c0 + 5, 32'h9, 32'h8, 32'h0, 32'h0, "bypass_mid_rise");
        expect_at(c0 + 7, 32'h9, 32'h0, 32'h0, 32'h0, "bypass_mid_hold");
        step(4);
        cfg_en = 1'b0;
        step(1);
        cfg_en = 1'b1;
        step(5);
        c0 = cyc;
        pin_in = '0;
        expect_at(c0 + 6, 32'h0, 32'h0, 32'h9, 32'h0, "cleanup_fall");
        step(9);

        // Bypass with a wide pattern.
        c0 = cyc;
        cfg_en = 1'b0;
        pin_in = 32'hA5A5_A5A5;
        expect_at(c0 + 2, 32'h0, 32'h0, 32'h0, 32'h0, "bypass_before");
        expect_at(c0 + 3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 32'h0, "bypass_rise");
        expect_at(c0 + 4, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, "bypass_hold");
        step(6);
        c0 = cyc;
        pin_in = '0;
        expect_at(c0 + 3, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0, "bypass_fall");
        step(6);
        cfg_en = 1'b1;

        // Interrupt pending flags on bit 2.
        irq_mask = 32'h4;
        c0 = cyc;
        pin_in[2] = 1'b1;
        expect_at(c0 + 6, 32'h4, 32'h4, 32'h0, 32'h0, "irq_rise");
        expect_at(c0 + 7, 32'h4, 32'h0, 32'h0, 32'h4, "irq_set_rise");
        expect_at(c0 + 8, 32'h4, 32'h0, 32'h0, 32'h4, "irq_sticky");
        expect_at(c0 + 9, 32'h4, 32'h0, 32'h0, 32'h0, "irq_ack1");
        step(8);
        irq_ack = 32'h4;
        step(1);
        irq_ack = '0;
        step(1);

        c1 = cyc;
        pin_in[2] = 1'b0;
        expect_at(c1 + 6, 32'h0, 32'h0, 32'h4, 32'h0, "irq_fall");
        expect_at(c1 + 7, 32'h0, 32'h0, 32'h0, 32'h4, "irq_set_fall");
        expect_at(c1 + 9, 32'h0, 32'h0, 32'h0, 32'h4, "irq_mask_keeps");
        expect_at(c1 + 10, 32'h0, 32'h0, 32'h0, 32'h0, "irq_ack2");
        step(8);
        irq_mask = '0;
        step(1);
        irq_ack = 32'h4;
        step(1);
        irq_ack  = '0;
        irq_mask = 32'h4;

        c2 = cyc;
        pin_in[2] = 1'b1;
        expect_at(c2 + 6, 32'h4, 32'h4, 32'h0, 32'h0, "irq_rise2");
        expect_at(c2 + 7, 32'h4, 32'h0, 32'h0, 32'h4, "irq_set_beats_ack");
        expect_at(c2 + 8, 32'h4, 32'h0, 32'h0, 32'h4, "irq_still_set");
        expect_at(c2 + 9, 32'h4, 32'h0, 32'h0, 32'h0, "irq_lone_ack");
        step(6);
        irq_ack = 32'h4;
        step(1);
        irq_ack = '0;
        step(1);
        irq_ack = 32'h4;
        step(1);
        irq_ack = '0;
        irq_mask = '0;
        c0 = cyc;
        pin_in[2] = 1'b0;
        expect_at(c0 + 6, 32'h0, 32'h0, 32'h4, 32'h0, "irq_cleanup_fall");
        step(9);

        // Asynchronous reset mid-count, then full latency from release.
        c0 = cyc;
        pin_in[0] = 1'b1;
        step(4);
        aresetn = 1'b0;
        expect_at(cyc, 32'h0, 32'h0, 32'h0, 32'h0, "areset_mid_count");
        step(1);
        aresetn = 1'b1;
        c1 = cyc;
        expect_at(c1 + 5, 32'h0, 32'h0, 32'h0, 32'h0, "areset_rel_before");
        expect_at(c1 + 6, 32'h1, 32'h1, 32'h0, 32'h0, "areset_rel_rise");
        expect_at(c1 + 7, 32'h1, 32'h0, 32'h0, 32'h0, "areset_rel_single");
        step(10);

        // Synchronous reset clears a fully set pending register.
        cfg_en = 1'b0;
        c0 = cyc;
        pin_in = '0;
        expect_at(c0 + 3, 32'h0, 32'h0, 32'h1, 32'h0, "srst_prep_fall");
        step(5);
        c0 = cyc;
        pin_in   = 32'hFFFF_FFFF;
        irq_mask = 32'hFFFF_FFFF;
        expect_at(c0 + 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, "srst_prep_rise");
        expect_at(c0 + 4, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, "srst_prep_pend");
        expect_at(c0 + 5, 32'h0, 32'h0, 32'h0, 32'h0, "srst_clear");
        expect_at(c0 + 7, 32'h0, 32'h0, 32'h0, 32'h0, "srst_resync");
        expect_at(c0 + 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, "srst_rerise");
        expect_at(c0 + 9, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, "srst_repend");
        step(4);
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        step(6);
        irq_mask = '0;
        step(4);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) step(1);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/friscv_gpio_filter.md
FRISCV_GPIO_FILTER -- requirements
Module: friscv_gpio_filter

Interface
REQ-001 Parameter XLEN, default 32, number of GPIO pins.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth (legal values 2-4).
REQ-003 Parameter DEBOUNCE_W, default 8, debounce counter and threshold width.
REQ-004 Port aclk, input, 1, single clock; all logic is rising-edge.
REQ-005 Port aresetn, input, 1, asynchronous active-low reset.
REQ-006 Port srst, input, 1, synchronous active-high reset.
REQ-007 Port cfg_en, input, 1, 1 = debounce active, 0 = bypass.
REQ-008 Port cfg_debounce, input, DEBOUNCE_W, debounce threshold in cycles.
REQ-009 Port pin_in, input, XLEN, raw asynchronous pad inputs.
REQ-010 Port gpio_in, output, XLEN, filtered pin levels, feeding the GPIO register block input port.
REQ-011 Port rise_pulse, output, XLEN, one-cycle pulse per bit on a filtered 0->1 transition.
REQ-012 Port fall_pulse, output, XLEN, one-cycle pulse per bit on a filtered 1->0 transition.
REQ-013 Port irq_mask, input, XLEN, per-bit edge interrupt enable.
REQ-014 Port irq_ack, input, XLEN, per-bit write-1-to-clear pulse for pending flags.
REQ-015 Port irq_pending, output, XLEN, sticky per-bit edge-event flags.
REQ-016 Port irq, output, 1, OR-reduction of irq_pending.

Function
REQ-017 Each pin_in bit SHALL pass through a SYNC_STAGES-deep flop chain; sync = last stage.
REQ-018 Per bit, a DEBOUNCE_W counter cnt and a filtered flop filt SHALL exist; gpio_in = filt.
REQ-019 cfg_en=1, sync==filt: cnt<=0, filt holds.
REQ-020 cfg_en=1, sync!=filt, cnt>=cfg_debounce: filt<=sync, cnt<=0.
REQ-021 cfg_en=1, sync!=filt, cnt<cfg_debounce: cnt<=cnt+1, filt holds; cnt never wraps.
REQ-022 Consequence: a stable level change appears on gpio_in SYNC_STAGES+cfg_debounce+1 cycles after it is sampled on pin_in; a glitch shorter than cfg_debounce+1 synchronized cycles is rejected.
REQ-023 cfg_debounce=0 SHALL give one cycle of filter latency; lowering cfg_debounce below an in-flight cnt SHALL update filt on the next edge.
REQ-024 cfg_en=0: filt<=sync every cycle, all cnt held at 0; toggling cfg_en mid-count SHALL not corrupt filt.
REQ-025 rise_pulse[i] SHALL be registered and high exactly in the first cycle gpio_in[i] reads 1 after reading 0; fall_pulse likewise for 1->0; both never high together.
REQ-026 irq_pending[i] SHALL set on (rise_pulse[i]|fall_pulse[i]) & irq_mask[i], registered one cycle after the pulse.
REQ-027 irq_pending[i] SHALL clear on the edge after irq_ack[i]=1; a simultaneous set and clear SHALL leave the bit set.
REQ-028 Masking a bit SHALL not clear an already set pending flag.
REQ-029 irq SHALL be the OR of irq_pending flops, with no extra latency.

Reset
REQ-030 aresetn low SHALL asynchronously clear sync chains, cnt, filt, rise_pulse, fall_pulse, and irq_pending; thus gpio_in=0 and irq=0.
REQ-031 srst high on a rising edge SHALL produce the same state as REQ-030 and take priority over all other updates.
REQ-032 After reset, a pin already high SHALL be treated as a 0->1 transition and produce one rise_pulse once filtered.

Verification
REQ-033 cfg_en=1, cfg_debounce=3, pin_in[0] 0->1 held -> gpio_in[0]=1 after exactly 6 cycles, rise_pulse[0] high that one cycle.
REQ-034 cfg_debounce=3, pin_in[5] high for 3 cycles then low -> gpio_in[5] stays 0, no pulses, irq stays 0.
REQ-035 cfg_en=0, pin_in=0xA5A5A5A5 -> gpio_in=0xA5A5A5A5 after 3 cycles; pulses on each rising bit only.
REQ-036 irq_mask[2]=1, pin_in[2] 1->0 filtered -> irq_pending[2]=1, irq=1; irq_ack[2] in the same cycle as a new edge -> bit stays 1; lone ack -> 0.
REQ-037 aresetn dropped mid-count with cnt=2 -> all outputs 0 immediately; after release with pin held 1 -> full latency, single rise_pulse.
REQ-038 srst asserted for one cycle with irq_pending=0xFFFFFFFF -> irq_pending=0, irq=0 on the next edge.
